// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
package div_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    ITER,
    FIX,
    DONE
  } state_t;

  // Wide enough for any supported operand width; users slice [tamano-1:0].
  localparam logic [63:0] DIV_ZERO_QUOTIENT = '1;

  // Width of the iteration counter, which must be able to hold tamano itself.
  function automatic int unsigned count_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/div_trial_sub.sv
// Combinational (tamano+1)-bit trial subtractor for one restoring-division step.
module div_trial_sub #(
  parameter int unsigned tamano = 8
) (
  input  logic [tamano:0] r_shift,
  input  logic [tamano:0] d,
  output logic [tamano:0] t,
  output logic            restore
);

  always_comb begin
    t       = r_shift - d;
    restore = t[tamano];
  end

endmodule

// File: rtl/seq_restoring_divider.sv
// Sequential shift-and-subtract divider, one quotient bit per clock.
// Define DIVIDER_SIGNED_EN for two's-complement operands.
module seq_restoring_divider
  import div_pkg::*;
#(
  parameter int unsigned tamano = 8
) (
  input  logic              CLOCK,
  input  logic              RESET,
  input  logic              START,
  input  logic [tamano-1:0] dividend,
  input  logic [tamano-1:0] divisor,
  output logic [tamano-1:0] quotient,
  output logic [tamano-1:0] remainder,
  output logic              busy,
  output logic              END_div,
  output logic              div_by_zero
);

  localparam int unsigned CW = count_width(tamano);

  state_t            state;
  logic [tamano-1:0] a_reg;
  logic [tamano-1:0] b_reg;
  logic [tamano-1:0] q_reg;
  logic [tamano:0]   r_reg;
  logic [tamano:0]   d_reg;
  logic [tamano:0]   r_shift;
  logic [tamano:0]   trial;
  logic              restore;
  logic [CW-1:0]     count;
  logic              zero_reg;

`ifdef DIVIDER_SIGNED_EN
  logic              a_neg;
  logic              b_neg;
  logic [tamano-1:0] a_mag;
  logic [tamano-1:0] b_mag;

  assign a_mag = a_reg[tamano-1] ? -a_reg : a_reg;
  assign b_mag = b_reg[tamano-1] ? -b_reg : b_reg;
`endif

  // r_reg[tamano] is always 0 after a step, so dropping it in the shift loses nothing.
  assign r_shift = (tamano+1)'({r_reg, q_reg[tamano-1]});

  div_trial_sub #(.tamano(tamano)) u_trial (
    .r_shift (r_shift),
    .d       (d_reg),
    .t       (trial),
    .restore (restore)
  );

  always_ff @(posedge CLOCK) begin
    if (!RESET) begin
      state       <= IDLE;
      quotient    <= '0;
      remainder   <= '0;
      busy        <= 1'b0;
      END_div     <= 1'b0;
      div_by_zero <= 1'b0;
      a_reg       <= '0;
      b_reg       <= '0;
      q_reg       <= '0;
      r_reg       <= '0;
      d_reg       <= '0;
      count       <= '0;
      zero_reg    <= 1'b0;
`ifdef DIVIDER_SIGNED_EN
      a_neg       <= 1'b0;
      b_neg       <= 1'b0;
`endif
    end else begin
      END_div <= 1'b0;
      unique case (state)
        IDLE: begin
          if (START) begin
            a_reg <= dividend;
            b_reg <= divisor;
            busy  <= 1'b1;
            state <= INIT;
          end
        end
        INIT: begin
          r_reg    <= '0;
          count    <= CW'(tamano);
          zero_reg <= (b_reg == '0);
`ifdef DIVIDER_SIGNED_EN
          q_reg    <= a_mag;
          d_reg    <= {1'b0, b_mag};
          a_neg    <= a_reg[tamano-1];
          b_neg    <= b_reg[tamano-1];
`else
          q_reg    <= a_reg;
          d_reg    <= {1'b0, b_reg};
`endif
          // Divide-by-zero also passes through FIX so both paths share the output load.
          state    <= (b_reg == '0) ? FIX : ITER;
        end
        ITER: begin
          q_reg <= {q_reg[tamano-2:0], ~restore};
          r_reg <= restore ? r_shift : trial;
          count <= count - CW'(1);
          if (count == CW'(1)) state <= FIX;
        end
        FIX: begin
          if (zero_reg) begin
            quotient    <= DIV_ZERO_QUOTIENT[tamano-1:0];
            remainder   <= a_reg;
            div_by_zero <= 1'b1;
          end else begin
`ifdef DIVIDER_SIGNED_EN
            quotient    <= (a_neg ^ b_neg) ? -q_reg : q_reg;
            remainder   <= a_neg ? -r_reg[tamano-1:0] : r_reg[tamano-1:0];
`else
            quotient    <= q_reg;
            remainder   <= r_reg[tamano-1:0];
`endif
            div_by_zero <= 1'b0;
          end
          END_div <= 1'b1;
          state   <= DONE;
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Directed scoreboard bench for seq_restoring_divider (tamano = 8).
module tb_seq_restoring_divider;

  localparam int unsigned W = 8;

  typedef struct packed {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         z;
  } exp_t;

  logic         CLOCK;
  logic         RESET;
  logic         START;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         busy;
  logic         END_div;
  logic         div_by_zero;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   edge_cnt = 0;
  int   accept_edge = 0;
  logic [W-1:0] last_q;

  seq_restoring_divider #(.tamano(W)) dut (
    .CLOCK       (CLOCK),
    .RESET       (RESET),
    .START       (START),
    .dividend    (dividend),
    .divisor     (divisor),
    .quotient    (quotient),
    .remainder   (remainder),
    .busy        (busy),
    .END_div     (END_div),
    .div_by_zero (div_by_zero)
  );

  initial begin
    CLOCK = 1'b0;
    forever #5 CLOCK = ~CLOCK;
  end

  always @(posedge CLOCK) edge_cnt <= edge_cnt + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    int   sa, sdv, qq;
    sa = 0; sdv = 0; qq = 0;
    if (b == '0) begin
      e.q = '1;
      e.r = a;
      e.z = 1'b1;
    end else begin
`ifdef DIVIDER_SIGNED_EN
      sa  = int'($signed(a));
      sdv = int'($signed(b));
      qq  = sa / sdv;
      e.q = W'(qq);
      e.r = W'(sa - qq * sdv);
`else
      e.q = a / b;
      e.r = a % b;
`endif
      e.z = 1'b0;
    end
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input bit push);
    @(negedge CLOCK);
    dividend = a;
    divisor  = b;
    START    = 1'b1;
    if (push) sb.push_back(model(a, b));
    @(posedge CLOCK);
    #1;
    accept_edge = edge_cnt;
    START    = 1'b0;
    dividend = ~a;
    divisor  = b ^ 8'h5A;
  endtask

  task automatic wait_end(input string tag, input int lat);
    int   n;
    exp_t e;
    n = 0;
    do begin
      @(negedge CLOCK);
      n++;
    end while (END_div !== 1'b1 && n < 60);
    chk({tag, "_lat"}, (END_div === 1'b1) ? 32'(edge_cnt - accept_edge) : 32'd999, 32'(lat));
    chk({tag, "_busy_done"}, 32'(busy), 32'd1);
    chk({tag, "_sb"}, 32'(sb.size() > 0), 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_q"}, 32'(quotient), 32'(e.q));
      chk({tag, "_r"}, 32'(remainder), 32'(e.r));
      chk({tag, "_dz"}, 32'(div_by_zero), 32'(e.z));
      last_q = e.q;
    end
    @(negedge CLOCK);
    chk({tag, "_end_pulse"}, 32'(END_div), 32'd0);
    chk({tag, "_busy_drop"}, 32'(busy), 32'd0);
  endtask

  task automatic do_div(input string tag, input logic [W-1:0] a, input logic [W-1:0] b);
    launch(a, b, 1'b1);
    wait_end(tag, (b == '0) ? 2 : W + 2);
  endtask

  initial begin
    int n_end;
    RESET    = 1'b0;
    START    = 1'b0;
    dividend = '0;
    divisor  = '0;
    last_q   = '0;
    repeat (3) @(posedge CLOCK);
    @(negedge CLOCK);
    chk("rst_q", 32'(quotient), 32'd0);
    chk("rst_r", 32'(remainder), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_end", 32'(END_div), 32'd0);
    chk("rst_dz", 32'(div_by_zero), 32'd0);
    RESET = 1'b1;

    do_div("basic", 8'd100, 8'd7);
    do_div("max", 8'hFF, 8'h01);
    do_div("small", 8'h05, 8'h09);
    do_div("zero", 8'h3C, 8'h00);
    do_div("after_zero", 8'd100, 8'd7);
    do_div("sgn_neg", 8'h9C, 8'd7);
    do_div("sgn_min", 8'h80, 8'hFF);

    // START while busy: the second request must be ignored.
    launch(8'd100, 8'd7, 1'b1);
    @(negedge CLOCK);
    chk("ign_busy_early", 32'(busy), 32'd1);
    repeat (3) @(posedge CLOCK);
    @(negedge CLOCK);
    chk("ign_hold_q", 32'(quotient), 32'(last_q));
    START    = 1'b1;
    dividend = 8'd200;
    divisor  = 8'd3;
    @(posedge CLOCK);
    #1;
    START = 1'b0;
    wait_end("ign", W + 2);
    repeat (3) @(negedge CLOCK);
    chk("ign_no_restart", 32'(busy), 32'd0);

    // START held high across DONE: next op accepted on the first IDLE edge.
    @(negedge CLOCK);
    dividend = 8'd50;
    divisor  = 8'd6;
    START    = 1'b1;
    sb.push_back(model(8'd50, 8'd6));
    @(posedge CLOCK);
    #1;
    accept_edge = edge_cnt;
    dividend = 8'd77;
    divisor  = 8'd5;
    sb.push_back(model(8'd77, 8'd5));
    wait_end("held_a", W + 2);
    @(posedge CLOCK);
    #1;
    accept_edge = edge_cnt;
    START    = 1'b0;
    dividend = 8'h11;
    divisor  = 8'h22;
    wait_end("held_b", W + 2);

    // Reset in the middle of an operation.
    launch(8'd100, 8'd7, 1'b0);
    repeat (4) @(posedge CLOCK);
    @(negedge CLOCK);
    RESET = 1'b0;
    @(negedge CLOCK);
    chk("mid_rst_q", 32'(quotient), 32'd0);
    chk("mid_rst_r", 32'(remainder), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_end", 32'(END_div), 32'd0);
    chk("mid_rst_dz", 32'(div_by_zero), 32'd0);
    RESET = 1'b1;
    n_end = 0;
    repeat (14) begin
      @(negedge CLOCK);
      if (END_div === 1'b1) n_end++;
    end
    chk("mid_rst_no_end", 32'(n_end), 32'd0);
    do_div("post_rst", 8'd100, 8'd7);

    for (int i = 0; i < 4; i++) begin
      do_div("rand", 8'($urandom_range(0, 255)), 8'($urandom_range(1, 255)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
